// File: rtl/rv32i_mc_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control unit: state encodings,
// ALU operation codes and the major opcodes the decoder dispatches on.
package rv32i_mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_ALU = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    JAL    = 4'd10,
    JALR   = 4'd11,
    LUI    = 4'd12,
    AUIPC  = 4'd13,
    TRAP   = 4'd14
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/rv32i_mc_ctrl_alu_op_decode.sv
// Maps funct3/funct7b5 to an ALU operation for register and immediate ALU ops.
module alu_op_decode
  import rv32i_mc_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [3:0] alu_code
);

  always_comb begin
    alu_code = ALU_ADD;
    unique case (funct3)
      // Bit 30 of an addi is immediate data, so only R-type may select SUB.
      3'b000: alu_code = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_code = ALU_SLL;
      3'b010: alu_code = ALU_SLT;
      3'b011: alu_code = ALU_SLTU;
      3'b100: alu_code = ALU_XOR;
      3'b101: alu_code = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_code = ALU_OR;
      3'b111: alu_code = ALU_AND;
      default: alu_code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and strobes, and counts retired instructions.
module rv32i_mc_ctrl
  import rv32i_mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUCode,
  output logic [3:0]  state,
  output logic        halted,
  output logic [31:0] retired
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_retired;
  logic [3:0]  w_dec_alu;
  logic        w_is_rtype;

  assign w_is_rtype = (r_state == EXEC_R);

  alu_op_decode u_alu_op_decode (
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .is_rtype (w_is_rtype),
    .alu_code (w_dec_alu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_retired <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state != FETCH && w_next == FETCH)
        r_retired <= r_retired + 32'd1;
    end
  end

  always_comb begin
    w_next   = r_state;
    mem_req  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 2'd0;
    RegWrite = 1'b0;
    MemtoReg = 2'd0;
    ALUSrcA  = 2'd0;
    ALUSrcB  = 2'd0;
    ALUCode  = ALU_ADD;
    halted   = 1'b0;
    unique case (r_state)
      FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'd2;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = 2'd1;
        unique case (opcode)
          OP_RTYPE:           w_next = EXEC_R;
          OP_ITYPE:           w_next = EXEC_I;
          OP_LOAD, OP_STORE:  w_next = ADDR;
          OP_BRANCH:          w_next = BRANCH;
          OP_JAL:             w_next = JAL;
          OP_JALR:            w_next = JALR;
          OP_LUI:             w_next = LUI;
          OP_AUIPC:           w_next = AUIPC;
          default:            w_next = TRAP;
        endcase
      end
      EXEC_R: begin
        ALUSrcA = 2'd1;
        ALUCode = w_dec_alu;
        w_next  = WB_ALU;
      end
      EXEC_I: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        ALUCode = w_dec_alu;
        w_next  = WB_ALU;
      end
      ADDR: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        w_next  = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) w_next = WB_MEM;
      end
      MEM_WR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) w_next = FETCH;
      end
      WB_ALU: begin
        RegWrite = 1'b1;
        w_next   = FETCH;
      end
      WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
        w_next   = FETCH;
      end
      BRANCH: begin
        PCWrite = branch_taken;
        PCSrc   = 2'd1;
        w_next  = FETCH;
      end
      JAL: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd2;
        PCWrite  = 1'b1;
        PCSrc    = 2'd1;
        w_next   = FETCH;
      end
      JALR: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd2;
        PCWrite  = 1'b1;
        PCSrc    = 2'd2;
        ALUSrcA  = 2'd1;
        ALUSrcB  = 2'd1;
        w_next   = FETCH;
      end
      LUI: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        w_next  = WB_ALU;
      end
      AUIPC: begin
        ALUSrcB = 2'd1;
        w_next  = WB_ALU;
      end
      TRAP: halted = 1'b1;
      default: w_next = TRAP;
    endcase

    // Reset overrides everything, including an in-flight memory write.
    if (reset) begin
      w_next   = FETCH;
      mem_req  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 2'd0;
      RegWrite = 1'b0;
      MemtoReg = 2'd0;
      ALUSrcA  = 2'd0;
      ALUSrcB  = 2'd0;
      ALUCode  = ALU_ADD;
      halted   = 1'b0;
    end
  end

  assign state   = r_state;
  assign retired = reset ? 32'd0 : r_retired;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Scoreboard bench for rv32i_mc_ctrl: each driven cycle pushes the expected
// outputs, and a negedge monitor pops and compares them against the DUT.
module tb_rv32i_mc_ctrl;
  import rv32i_mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, halted;
  logic [1:0]  PCSrc, MemtoReg, ALUSrcA, ALUSrcB;
  logic [3:0]  ALUCode, state;
  logic [31:0] retired;

  typedef struct packed {
    logic [3:0]  st;
    logic        req;
    logic        rd;
    logic        wr;
    logic        ir;
    logic        pcw;
    logic [1:0]  pcsrc;
    logic        rw;
    logic [1:0]  m2r;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [3:0]  alu;
    logic        halt;
    logic [31:0] ret;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } sb_item_t;

  sb_item_t sb[$];
  sb_item_t mon_item;
  obs_t     mon_obs;
  int       n_checks = 0;
  int       n_errors = 0;
  int       exp_ret  = 0;
  state_t   prev_st  = FETCH;

  rv32i_mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUCode(ALUCode), .state(state), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs per state, written from the state table.
  function automatic obs_t model(state_t s, logic mr, logic bt, logic [3:0] alu, logic [31:0] ret);
    obs_t o = '0;
    o.st  = s;
    o.ret = ret;
    case (s)
      FETCH:  begin o.req = 1; o.rd = 1; o.b = 2; o.ir = mr; o.pcw = mr; end
      DECODE: o.b = 1;
      EXEC_R: begin o.a = 1; o.alu = alu; end
      EXEC_I: begin o.a = 1; o.b = 1; o.alu = alu; end
      ADDR:   begin o.a = 1; o.b = 1; end
      MEM_RD: begin o.req = 1; o.rd = 1; end
      MEM_WR: begin o.req = 1; o.wr = 1; end
      WB_ALU: o.rw = 1;
      WB_MEM: begin o.rw = 1; o.m2r = 1; end
      BRANCH: begin o.pcw = bt; o.pcsrc = 1; end
      JAL:    begin o.rw = 1; o.m2r = 2; o.pcw = 1; o.pcsrc = 1; end
      JALR:   begin o.rw = 1; o.m2r = 2; o.pcw = 1; o.pcsrc = 2; o.a = 1; o.b = 1; end
      LUI:    begin o.a = 2; o.b = 1; end
      AUIPC:  o.b = 1;
      TRAP:   o.halt = 1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic set_instr(input logic [31:0] ins);
    opcode   = ins[6:0];
    funct3   = ins[14:12];
    funct7b5 = ins[30];
  endtask

  task automatic drive(input state_t s, input logic mr, input logic bt, input logic [3:0] alu);
    sb_item_t it;
    reset        = 1'b0;
    mem_ready    = mr;
    branch_taken = bt;
    if (s == FETCH && prev_st != FETCH) exp_ret++;
    prev_st = s;
    it.tag = s.name();
    it.exp = model(s, mr, bt, alu, exp_ret);
    sb.push_back(it);
    @(posedge clk); #1;
  endtask

  // One reset cycle while the FSM sits in state s; mem_ready is held high to
  // show that reset wins.
  task automatic drive_reset(input state_t s);
    sb_item_t it;
    reset        = 1'b1;
    mem_ready    = 1'b1;
    branch_taken = 1'b1;
    it.tag    = "reset";
    it.exp    = '0;
    it.exp.st = s;
    sb.push_back(it);
    @(posedge clk); #1;
    reset   = 1'b0;
    exp_ret = 0;
    prev_st = FETCH;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_item = sb.pop_front();
      mon_obs  = {state, mem_req, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite,
                  MemtoReg, ALUSrcA, ALUSrcB, ALUCode, halted, retired};
      chk(mon_item.tag, {9'd0, mon_obs}, {9'd0, mon_item.exp});
      $display("cycle t=%0t %s state=%0d strobes req=%b rd=%b wr=%b rw=%b pcw=%b retired=%0d",
               $time, mon_item.tag, state, mem_req, MemRead, MemWrite, RegWrite, PCWrite, retired);
    end
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0;
    set_instr(32'h0);
    @(posedge clk); #1;
    drive_reset(FETCH);

    // lui
    set_instr(32'h00003f37);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD);
    drive(LUI, 0, 0, ALU_ADD);   drive(WB_ALU, 0, 0, ALU_ADD);
    chk("lui_retired", {32'd0, retired}, 64'd1);

    // lw with one fetch wait and three memory wait cycles
    set_instr(32'h00432e83);
    drive(FETCH, 0, 0, ALU_ADD); drive(FETCH, 1, 0, ALU_ADD);
    drive(DECODE, 0, 0, ALU_ADD); drive(ADDR, 0, 0, ALU_ADD);
    for (int i = 0; i < 3; i++) drive(MEM_RD, 0, 0, ALU_ADD);
    drive(MEM_RD, 1, 0, ALU_ADD); drive(WB_MEM, 0, 0, ALU_ADD);

    // beq taken, then not taken
    set_instr(32'hfc000a63);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD); drive(BRANCH, 0, 1, ALU_ADD);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD); drive(BRANCH, 0, 0, ALU_ADD);

    // ALU ops: sub, slli, srai, addi with bit30 set, sra
    set_instr(32'h406283b3);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD);
    drive(EXEC_R, 0, 0, ALU_SUB); drive(WB_ALU, 0, 0, ALU_ADD);
    set_instr(32'h002e9293);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD);
    drive(EXEC_I, 0, 0, ALU_SLL); drive(WB_ALU, 0, 0, ALU_ADD);
    set_instr(32'h4052d293);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD);
    drive(EXEC_I, 0, 0, ALU_SRA); drive(WB_ALU, 0, 0, ALU_ADD);
    set_instr(32'h40028293);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD);
    drive(EXEC_I, 0, 0, ALU_ADD); drive(WB_ALU, 0, 0, ALU_ADD);
    set_instr(32'h4052d2b3);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD);
    drive(EXEC_R, 0, 0, ALU_SRA); drive(WB_ALU, 0, 0, ALU_ADD);

    // jal, jalr, auipc
    set_instr(32'h0000006f);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD); drive(JAL, 0, 0, ALU_ADD);
    set_instr(32'h00008067);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD); drive(JALR, 0, 0, ALU_ADD);
    set_instr(32'h00000297);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD);
    drive(AUIPC, 0, 0, ALU_ADD); drive(WB_ALU, 0, 0, ALU_ADD);

    // sw completing after one wait cycle
    set_instr(32'h001c2623);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD); drive(ADDR, 0, 0, ALU_ADD);
    drive(MEM_WR, 0, 0, ALU_ADD); drive(MEM_WR, 1, 0, ALU_ADD);

    // illegal opcode traps and holds for ten cycles until reset
    set_instr(32'h00000000);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD);
    for (int i = 0; i < 10; i++) drive(TRAP, 1'($urandom_range(0, 1)), 1, ALU_ADD);
    drive_reset(TRAP);

    // sw aborted by reset in its second MEM_WR cycle
    set_instr(32'h001c2623);
    drive(FETCH, 1, 0, ALU_ADD); drive(DECODE, 0, 0, ALU_ADD); drive(ADDR, 0, 0, ALU_ADD);
    drive(MEM_WR, 0, 0, ALU_ADD);
    drive_reset(MEM_WR);
    drive(FETCH, 0, 0, ALU_ADD);
    chk("sw_abort_retired", {32'd0, retired}, 64'd0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
